// File: rtl/lcd_line_arbiter.sv
// ============================================================================
// lcd_line_arbiter
// ----------------------------------------------------------------------------
// Shares a 16x2 character LCD (HD44780-style 8-bit bus) between two line
// writers. After reset the block runs the LCD power-up command sequence once.
// It then grants whole-line writes (address command + 16 characters) to the
// two requesters in round-robin order and drives the LCD bus with a generated
// E strobe.
//
// Optional feature (compile-time macro):
//   LCD_ARB_CHAR_FILTER_EN - when defined, any fetched character byte outside
//                            0x20..0x7E is replaced by 0x20 (space) before it
//                            reaches LCD_DATA. Command bytes are never filtered.
//
// Parameters:
//   CLKS_PER_STEP - clock cycles per LCD bus write step (legal 3..15)
//   INIT_WAIT     - idle cycles after reset before the first command
//   CLEAR_WAIT    - idle cycles after the clear-display command
//
// Ports:
//   clk         in   system clock
//   resetn      in   synchronous reset, active HIGH despite the name
//   req[1:0]    in   bit i = requester i wants to write one full line
//   req_line    in   bit i = target line of requester i (0 = line 1)
//   char_data0  in   requester 0 character for position char_idx
//   char_data1  in   requester 1 character for position char_idx
//   gnt[1:0]    out  one-hot grant, held for the whole transfer
//   done[1:0]   out  one-cycle pulse when requester i's line is complete
//   char_idx    out  character position 0..15 being fetched
//   busy        out  high whenever the FSM is not in IDLE
//   LCD_E       out  LCD enable strobe
//   LCD_RS      out  0 = command, 1 = data
//   LCD_RW      out  tied to write
//   LCD_DATA    out  LCD data bus
//
// State table:
//   state        | meaning
//   -------------+------------------------------------------------------
//   ST_INIT_WAIT | power-up delay, INIT_WAIT cycles
//   ST_FSET      | command step 0x3C (function set, 8-bit, 2 lines)
//   ST_DISP      | command step 0x0C (display on, cursor off)
//   ST_ENTRY     | command step 0x06 (entry mode, increment)
//   ST_CLR       | command step 0x01 (clear display)
//   ST_CLR_WAIT  | clear execution delay, CLEAR_WAIT cycles
//   ST_IDLE      | waiting for a request, arbitration point
//   ST_ADDR      | command step 0x80 / 0xC0 (DDRAM address of the line)
//   ST_CHARS     | 16 data steps, one per character
//   ST_DONE      | one cycle, done pulse to the winner
// ============================================================================
module lcd_line_arbiter #(
    parameter int CLKS_PER_STEP = 4,
    parameter int INIT_WAIT     = 70,
    parameter int CLEAR_WAIT    = 200
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic [1:0] req_line,
    input  logic [7:0] char_data0,
    input  logic [7:0] char_data1,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic [3:0] char_idx,
    output logic       busy,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int WAIT_MAX = (INIT_WAIT > CLEAR_WAIT) ? INIT_WAIT : CLEAR_WAIT;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int STEP_W   = 4;

    localparam logic [WAIT_W-1:0] INIT_LOAD  = WAIT_W'(INIT_WAIT - 1);
    localparam logic [WAIT_W-1:0] CLEAR_LOAD = WAIT_W'(CLEAR_WAIT - 1);

    // Step counter counts down from S-1 (step cycle 0) to 0 (step cycle S-1).
    localparam logic [STEP_W-1:0] STEP_LOAD   = STEP_W'(CLKS_PER_STEP - 1);
    // Value of the step counter during step cycle 1: character sample point.
    localparam logic [STEP_W-1:0] STEP_SAMPLE = STEP_W'(CLKS_PER_STEP - 2);

    localparam logic [7:0] CMD_FSET  = 8'h3C;
    localparam logic [7:0] CMD_DISP  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY = 8'h06;
    localparam logic [7:0] CMD_CLR   = 8'h01;
    localparam logic [7:0] CMD_LINE1 = 8'h80;
    localparam logic [7:0] CMD_LINE2 = 8'hC0;

    typedef enum logic [3:0] {
        ST_INIT_WAIT,
        ST_FSET,
        ST_DISP,
        ST_ENTRY,
        ST_CLR,
        ST_CLR_WAIT,
        ST_IDLE,
        ST_ADDR,
        ST_CHARS,
        ST_DONE
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [WAIT_W-1:0]   r_wait;
    logic [STEP_W-1:0]   r_step_left;
    logic                r_last;
    logic                r_win;
    logic [1:0]          r_gnt;
    logic [1:0]          r_done;
    logic [3:0]          r_char_idx;
    logic                r_busy;
    logic                r_lcd_e;
    logic                r_lcd_rs;
    logic [7:0]          r_lcd_data;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic       w_step_end;
    logic       w_pick;
    logic [7:0] w_char_raw;
    logic [7:0] w_char;

    assign w_step_end = (r_step_left == '0);

    // Round-robin: a lone requester wins; on a tie the one that was not
    // served last wins. For a lone requester, req[1] is its index.
    always_comb begin
        w_pick = req[1];
        if (req == 2'b11) begin
            w_pick = ~r_last;
        end
    end

    assign w_char_raw = r_win ? char_data1 : char_data0;

`ifdef LCD_ARB_CHAR_FILTER_EN
    // Non-printable bytes would show as garbage glyphs; substitute a space.
    assign w_char = ((w_char_raw < 8'h20) || (w_char_raw > 8'h7E)) ? 8'h20 : w_char_raw;
`else
    assign w_char = w_char_raw;
`endif

    // ------------------------------------------------------------------------
    // Sequencer / arbiter FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (resetn) begin
            r_state     <= ST_INIT_WAIT;
            r_wait      <= INIT_LOAD;
            r_step_left <= '0;
            r_last      <= 1'b1;
            r_win       <= 1'b0;
            r_gnt       <= 2'b00;
            r_done      <= 2'b00;
            r_char_idx  <= 4'd0;
            r_busy      <= 1'b1;
            r_lcd_e     <= 1'b0;
            r_lcd_rs    <= 1'b0;
            r_lcd_data  <= 8'h00;
        end else begin
            r_done <= 2'b00;

            // Generic step timing. E is raised for step cycles 1..S-2: when
            // moving into cycle c+1 the counter will read S-2-c, so E is high
            // for the next cycle exactly when the current counter is >= 2.
            // States that end a step override the counter reload below.
            if (w_step_end) begin
                r_lcd_e <= 1'b0;
            end else begin
                r_step_left <= r_step_left - STEP_W'(1);
                r_lcd_e     <= (r_step_left >= STEP_W'(2));
            end

            case (r_state)
                ST_INIT_WAIT: begin
                    if (r_wait == '0) begin
                        r_state     <= ST_FSET;
                        r_step_left <= STEP_LOAD;
                        r_lcd_rs    <= 1'b0;
                        r_lcd_data  <= CMD_FSET;
                    end else begin
                        r_wait <= r_wait - WAIT_W'(1);
                    end
                end

                ST_FSET: begin
                    if (w_step_end) begin
                        r_state     <= ST_DISP;
                        r_step_left <= STEP_LOAD;
                        r_lcd_data  <= CMD_DISP;
                    end
                end

                ST_DISP: begin
                    if (w_step_end) begin
                        r_state     <= ST_ENTRY;
                        r_step_left <= STEP_LOAD;
                        r_lcd_data  <= CMD_ENTRY;
                    end
                end

                ST_ENTRY: begin
                    if (w_step_end) begin
                        r_state     <= ST_CLR;
                        r_step_left <= STEP_LOAD;
                        r_lcd_data  <= CMD_CLR;
                    end
                end

                ST_CLR: begin
                    if (w_step_end) begin
                        r_state <= ST_CLR_WAIT;
                        r_wait  <= CLEAR_LOAD;
                    end
                end

                ST_CLR_WAIT: begin
                    if (r_wait == '0) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_wait <= r_wait - WAIT_W'(1);
                    end
                end

                ST_IDLE: begin
                    if (req != 2'b00) begin
                        r_state     <= ST_ADDR;
                        r_win       <= w_pick;
                        r_last      <= w_pick;
                        r_gnt       <= w_pick ? 2'b10 : 2'b01;
                        r_busy      <= 1'b1;
                        r_char_idx  <= 4'd0;
                        r_step_left <= STEP_LOAD;
                        r_lcd_rs    <= 1'b0;
                        // The target line is only needed for the address
                        // command, so capturing it here is the only use.
                        r_lcd_data  <= req_line[w_pick] ? CMD_LINE2 : CMD_LINE1;
                    end
                end

                ST_ADDR: begin
                    if (w_step_end) begin
                        // First data step keeps the address byte on the bus
                        // until the first character has been fetched.
                        r_state     <= ST_CHARS;
                        r_step_left <= STEP_LOAD;
                        r_lcd_rs    <= 1'b1;
                    end
                end

                ST_CHARS: begin
                    // Requester presents char_data one cycle after char_idx
                    // changes (registered ROM), so sample in step cycle 1.
                    if (r_step_left == STEP_SAMPLE) begin
                        r_lcd_data <= w_char;
                    end
                    if (w_step_end) begin
                        if (r_char_idx == 4'd15) begin
                            r_state <= ST_DONE;
                            r_done  <= r_win ? 2'b10 : 2'b01;
                        end else begin
                            r_char_idx  <= r_char_idx + 4'd1;
                            r_step_left <= STEP_LOAD;
                        end
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 2'b00;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= ST_INIT_WAIT;
                    r_wait  <= INIT_LOAD;
                    r_gnt   <= 2'b00;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign gnt      = r_gnt;
    assign done     = r_done;
    assign char_idx = r_char_idx;
    assign busy     = r_busy;
    assign LCD_E    = r_lcd_e;
    assign LCD_RS   = r_lcd_rs;
    assign LCD_RW   = 1'b0;
    assign LCD_DATA = r_lcd_data;

endmodule

// File: doc/lcd_line_arbiter.md
# lcd_line_arbiter

Shares the 16x2 character LCD between two requesters, e.g. the slot-game result logic and a status/score source. After reset it runs the LCD power-up command sequence once. It then grants whole-line writes to the requesters in round-robin order and drives the LCD bus with a generated E strobe. It sits between the game logic and the LCD pins and replaces any free-running per-state LCD driver.

## Interface
- CLKS_PER_STEP, 4: clock cycles per LCD bus write step; legal values 3–15.
- INIT_WAIT, 70: idle cycles after reset before the first command.
- CLEAR_WAIT, 200: idle cycles after the clear-display command.

- clk  in  1  system clock.
- resetn  in  1  synchronous, active-high reset. It is sampled on the rising edge of clk; 1 = reset.
- req  in  2  bit i = requester i wants to write one full line.
- req_line  in  2  bit i = target line for requester i (0 = line 1, 1 = line 2).
- char_data0  in  8  ASCII byte from requester 0 for position char_idx.
- char_data1  in  8  ASCII byte from requester 1 for position char_idx.
- gnt  out  2  one-hot grant, held for the whole transfer.
- done  out  2  one-cycle pulse on bit i when requester i's line is complete.
- char_idx  out  4  character position 0–15 being fetched.
- busy  out  1  high when the block is not in IDLE.
- LCD_E  out  1  LCD enable strobe.
- LCD_RS  out  1  0 = command, 1 = data.
- LCD_RW  out  1  always 0 after reset (write only).
- LCD_DATA  out  8  LCD data bus.

## Operation
- Reset values:
  - state = INIT_WAIT.
  - LCD_E = 0, LCD_RS = 0, LCD_RW = 0, LCD_DATA = 0x00.
  - gnt = 00, done = 00, char_idx = 0, busy = 1.
  - Round-robin pointer last = 1, so requester 0 wins the first tie.
- Write step (S = CLKS_PER_STEP cycles):
  - Step cycle 0: LCD_RS and LCD_DATA are updated. They are held stable for the whole step.
  - LCD_E is high on step cycles 1..S-2 and low on cycle 0 and cycle S-1.
- State sequence:
  - INIT_WAIT (INIT_WAIT cycles)
  - FSET: command 0x3C
  - DISP: command 0x0C
  - ENTRY: command 0x06
  - CLR: command 0x01
  - CLR_WAIT (CLEAR_WAIT cycles)
  - IDLE
  - ADDR: command 0x80 for line 1, 0xC0 for line 2
  - CHARS: 16 data steps
  - DONE: 1 cycle
  - back to IDLE
- The init sequence runs only after reset. Requests raised during init are held off; gnt stays 00.
- Arbitration, evaluated in IDLE:
  - Only one requester asserting req: it wins.
  - Both asserting req: the requester other than `last` wins.
  - `last` updates to the winner at grant.
- req_line of the winner is captured at grant. Later changes to it are ignored until the next grant.
- CHARS fetch:
  - char_idx = k during data step k.
  - The winner's char_data is sampled on step cycle 1 and driven on LCD_DATA from step cycle 2.
  - The requester therefore has a 1-cycle fetch latency, which allows a registered ROM.
  - For data steps, LCD_DATA on step cycle 0..1 holds the previous byte.
- DONE: done[winner] = 1 for exactly one cycle. gnt returns to 00 the following cycle.
- A requester still asserting req after its done pulse is re-arbitrated normally. If both are pending, the other requester is served first.
- Reset asserted mid-transfer: gnt goes to 00, no done pulse is issued, and the full init sequence repeats.

## Timing
- Reset to busy = 0: INIT_WAIT + 4·S + CLEAR_WAIT cycles. This is 286 cycles at the defaults.
- req sampled high in IDLE on cycle t → gnt high from cycle t+1.
- gnt stays high for 17·S + 1 cycles. done pulses in the last of these cycles.
- Minimum gap between consecutive grants: one IDLE cycle.
- The last char_idx value (15) holds until the next transfer. char_idx resets to 0 at grant.

## Configuration
- LCD_ARB_CHAR_FILTER_EN:
  - Defined: any sampled character byte outside 0x20–0x7E is replaced by 0x20 (space) before it is driven on LCD_DATA. Command bytes are never filtered.
  - Undefined: character bytes pass through unchanged.

## Test plan
- **Power-up:** deassert resetn with defaults → commands 0x3C, 0x0C, 0x06, 0x01 are seen with LCD_RS = 0, each with E high for 2 cycles; busy falls at cycle 286.
- **Single write:** req = 01, req_line = 01 (requester 0, line 2), char_data0 = "GAME START!     " → 0xC0 is seen, then 16 data bytes in order with RS = 1; done = 01 for 1 cycle; gnt high for 69 cycles.
- **Contention:** req = 11 held → grant order is 01, 10, 01; done bits alternate.
- **Request during init:** req = 10 asserted at cycle 5 → gnt stays 00 until IDLE is reached, then gnt = 10 on the next cycle.
- **Reset mid-transfer:** assert resetn while char_idx = 7 → gnt = 00 and no done pulse; the init sequence reruns from INIT_WAIT.
- **Character filter:** char_data0 = 0x07 at char_idx 3 → LCD_DATA = 0x20 with LCD_ARB_CHAR_FILTER_EN defined, and 0x07 without it.
